// File: rtl/dram_seq_pkg.sv
// dram_seq_pkg: shared FSM state encoding and address-width helper for the DRAM sequencer.
package dram_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_COL,
        S_CAS,
        S_PRE,
        S_RCAS,
        S_RRAS
    } state_e;

    localparam int CNT_W = 16;

    function automatic int addr_w(input int row_bits, input int col_bits);
        return (row_bits > col_bits) ? row_bits : col_bits;
    endfunction

endpackage

// File: rtl/dram_seq_refresh_timer.sv
// dram_seq_refresh_timer: free-running refresh interval counter with pending flag and late pulse.
module dram_seq_refresh_timer #(
    parameter int REF_INTERVAL = 390
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ref_taken_i,
    output logic ref_pending_o,
    output logic ref_late_o
);

    localparam int W = $clog2(REF_INTERVAL);

    logic [W-1:0] cnt_q;
    logic         pend_q;
    logic         late_q;
    logic         wrap;

    assign wrap          = (cnt_q == W'(REF_INTERVAL - 1));
    assign ref_pending_o = pend_q;
    assign ref_late_o    = late_q;

    // A wrap always re-arms the request, even if it coincides with the refresh being taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            late_q <= 1'b0;
        end else begin
            cnt_q  <= wrap ? '0 : cnt_q + 1'b1;
            pend_q <= wrap | (pend_q & ~ref_taken_i);
            late_q <= wrap & pend_q & ~ref_taken_i;
        end
    end

endmodule

// File: rtl/dram_seq.sv
// dram_seq: async-DRAM access sequencer with programmable RAS/MUX/CAS/precharge timing and CBR refresh.
module dram_seq
    import dram_seq_pkg::*;
#(
    parameter int ROW_BITS     = 8,
    parameter int COL_BITS     = 8,
    parameter int T_ROW        = 1,
    parameter int T_MUX        = 1,
    parameter int T_CAS        = 2,
    parameter int T_PRE        = 1,
    parameter int T_REF        = 2,
    parameter int REF_INTERVAL = 390,
    localparam int ADDR_W      = addr_w(ROW_BITS, COL_BITS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req,
    input  logic                         we,
    input  logic [ROW_BITS+COL_BITS-1:0] addr,
    output logic                         ready,
    output logic                         ack,
    output logic                         ras_n,
    output logic                         cas_n,
    output logic                         we_n,
    output logic                         mux,
    output logic [ADDR_W-1:0]            dram_addr,
    output logic                         ref_late
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  row_q, row_d, col_q, col_d;
    logic               ref_pending, ref_taken, accept, done, in_acc;

    function automatic logic [CNT_W-1:0] phase_len(input state_e s);
        return (s == S_ROW)  ? CNT_W'(T_ROW - 1) :
               (s == S_COL)  ? CNT_W'(T_MUX - 1) :
               (s == S_CAS)  ? CNT_W'(T_CAS - 1) :
               (s == S_PRE)  ? CNT_W'(T_PRE - 1) :
               (s == S_RRAS) ? CNT_W'(T_REF - 1) : '0;
    endfunction

    dram_seq_refresh_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .ref_taken_i  (ref_taken),
        .ref_pending_o(ref_pending),
        .ref_late_o   (ref_late)
    );

    assign ready     = (state_q == S_IDLE) & ~ref_pending;
    assign accept    = ready & req;
    assign ref_taken = (state_q == S_IDLE) & ref_pending;
    assign done      = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = ref_pending ? S_RCAS : (req ? S_ROW : S_IDLE);
            S_ROW:   state_d = done ? S_COL : S_ROW;
            S_COL:   state_d = done ? S_CAS : S_COL;
            S_CAS:   state_d = done ? S_PRE : S_CAS;
            S_PRE:   state_d = done ? S_IDLE : S_PRE;
            S_RCAS:  state_d = S_RRAS;
            S_RRAS:  state_d = done ? S_PRE : S_RRAS;
            default: state_d = S_IDLE;
        endcase
    end

    assign cnt_d  = (state_d != state_q) ? phase_len(state_d) : (done ? cnt_q : cnt_q - 1'b1);
    assign we_d   = accept ? we : we_q;
    assign row_d  = accept ? ADDR_W'(addr[ROW_BITS+COL_BITS-1:COL_BITS]) : row_q;
    assign col_d  = accept ? ADDR_W'(addr[COL_BITS-1:0]) : col_q;
    assign in_acc = state_d inside {S_ROW, S_COL, S_CAS};

    // Pins are decoded from the next state so they switch on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            ras_n     <= 1'b1;
            cas_n     <= 1'b1;
            we_n      <= 1'b1;
            mux       <= 1'b0;
            ack       <= 1'b0;
            dram_addr <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            row_q     <= row_d;
            col_q     <= col_d;
            ras_n     <= ~(in_acc | (state_d == S_RRAS));
            cas_n     <= ~(state_d inside {S_CAS, S_RCAS, S_RRAS});
            we_n      <= in_acc ? ~we_d : 1'b1;
            mux       <= state_d inside {S_COL, S_CAS};
            ack       <= (state_d == S_CAS) & (cnt_d == '0);
            dram_addr <= (state_d inside {S_COL, S_CAS}) ? col_d : row_d;
        end
    end

endmodule

// File: tb/tb_dram_seq.sv
// tb_dram_seq: directed vector and multi-cycle sequence bench for dram_seq.
module tb_dram_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic a_req = 0, a_we = 0, a_ready, a_ack, a_ras_n, a_cas_n, a_we_n, a_mux, a_late;
    logic w_req = 0, w_we = 0, w_ready, w_ack, w_ras_n, w_cas_n, w_we_n, w_mux, w_late;
    logic r_req = 0, r_we = 0, r_ready, r_ack, r_ras_n, r_cas_n, r_we_n, r_mux, r_late;
    logic l_req = 0, l_we = 0, l_ready, l_ack, l_ras_n, l_cas_n, l_we_n, l_mux, l_late;
    logic [15:0] a_addr = 0, w_addr = 0, r_addr = 0, l_addr = 0;
    logic [7:0]  a_da, w_da, r_da, l_da;

    dram_seq u_a (
        .clk(clk), .rst_n(rst_n), .req(a_req), .we(a_we), .addr(a_addr), .ready(a_ready),
        .ack(a_ack), .ras_n(a_ras_n), .cas_n(a_cas_n), .we_n(a_we_n), .mux(a_mux),
        .dram_addr(a_da), .ref_late(a_late)
    );

    dram_seq #(.T_ROW(2), .T_MUX(1), .T_CAS(3)) u_w (
        .clk(clk), .rst_n(rst_n), .req(w_req), .we(w_we), .addr(w_addr), .ready(w_ready),
        .ack(w_ack), .ras_n(w_ras_n), .cas_n(w_cas_n), .we_n(w_we_n), .mux(w_mux),
        .dram_addr(w_da), .ref_late(w_late)
    );

    dram_seq #(.REF_INTERVAL(16)) u_r (
        .clk(clk), .rst_n(rst_n), .req(r_req), .we(r_we), .addr(r_addr), .ready(r_ready),
        .ack(r_ack), .ras_n(r_ras_n), .cas_n(r_cas_n), .we_n(r_we_n), .mux(r_mux),
        .dram_addr(r_da), .ref_late(r_late)
    );

    dram_seq #(.T_CAS(24), .REF_INTERVAL(16)) u_l (
        .clk(clk), .rst_n(rst_n), .req(l_req), .we(l_we), .addr(l_addr), .ready(l_ready),
        .ack(l_ack), .ras_n(l_ras_n), .cas_n(l_cas_n), .we_n(l_we_n), .mux(l_mux),
        .dram_addr(l_da), .ref_late(l_late)
    );

    // exp = {ready, ras_n, cas_n, we_n, mux, ack}, sampled after the edge the inputs are applied to
    typedef struct {
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [5:0]  exp;
        logic [7:0]  da;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int ack_at[$];
        int ras_hi, we_lo, cas_lo, acks, ack_cas, lates, rcas;
        logic found, prev_ready;
        logic [1:0] ref_exp[6];

        vecs[0]  = '{1'b1, 1'b0, 16'hA55A, 6'b001100, 8'hA5};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 6'b001110, 8'h5A};
        vecs[2]  = '{1'b1, 1'b1, 16'hFFFF, 6'b000110, 8'h5A};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 6'b000111, 8'h5A};
        vecs[4]  = '{1'b1, 1'b1, 16'hFFFF, 6'b011100, 8'hA5};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 6'b111100, 8'hA5};
        vecs[6]  = '{1'b1, 1'b1, 16'h1234, 6'b001000, 8'h12};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 6'b001010, 8'h34};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 6'b000010, 8'h34};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 6'b000011, 8'h34};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 6'b011100, 8'h12};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 6'b111100, 8'h12};
        ref_exp = '{2'b10, 2'b00, 2'b00, 2'b11, 2'b11, 2'b01};

        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_pins", {a_ready, a_ras_n, a_cas_n, a_we_n, a_mux, a_ack}, 6'b111100);
        chk("reset_addr", a_da, 8'h00);
        chk("reset_late", a_late, 1'b0);

        for (int i = 0; i < 12; i++) begin
            a_req = vecs[i].req; a_we = vecs[i].we; a_addr = vecs[i].addr;
            @(negedge clk);
            chk($sformatf("vec%0d_pins", i), {a_ready, a_ras_n, a_cas_n, a_we_n, a_mux, a_ack}, vecs[i].exp);
            chk($sformatf("vec%0d_addr", i), a_da, vecs[i].da);
        end
        a_req = 1'b0;

        // back-to-back: req held high, acks expected after edges 4, 10 and 16
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0102;
        ras_hi = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (a_ack) ack_at.push_back(i);
            if (a_ras_n && ack_at.size() == 1) ras_hi++;
        end
        a_req = 1'b0;
        chk("b2b_ack_count", ack_at.size(), 3);
        if (ack_at.size() == 3) begin
            chk("b2b_first_ack", ack_at[0], 4);
            chk("b2b_spacing1", ack_at[1] - ack_at[0], 6);
            chk("b2b_spacing2", ack_at[2] - ack_at[1], 6);
        end
        chk("b2b_ras_high_gap", ras_hi >= 1, 1'b1);
        repeat (4) @(negedge clk);

        // write with T_ROW=2, T_MUX=1, T_CAS=3
        w_req = 1'b1; w_we = 1'b1; w_addr = 16'hBEEF;
        we_lo = 0; cas_lo = 0; acks = 0; ack_cas = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            w_req = 1'b0;
            if (i == 1) chk("wr_row_addr", w_da, 8'hBE);
            if (!w_we_n) we_lo++;
            if (!w_cas_n) cas_lo++;
            if (w_ack) begin acks++; ack_cas = cas_lo; end
        end
        chk("wr_we_n_cycles", we_lo, 6);
        chk("wr_cas_n_cycles", cas_lo, 3);
        chk("wr_ack_count", acks, 1);
        chk("wr_ack_on_3rd_cas", ack_cas, 3);

        // refresh priority: req raised in the cycle ref_pending sets
        found = 1'b0; prev_ready = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (prev_ready && !r_ready) found = 1'b1;
            prev_ready = r_ready;
        end
        chk("ref_pending_seen", found, 1'b1);
        r_req = 1'b1; r_we = 1'b0; r_addr = 16'h0102;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("ref_seq%0d_strobes", i), {r_ras_n, r_cas_n}, ref_exp[i]);
        end
        chk("ref_ready_after_pre", r_ready, 1'b0);
        chk("ref_req_row_addr", r_da, 8'h01);
        r_req = 1'b0;

        // starvation: one long access spanning two interval wraps
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (l_ras_n && !l_cas_n) found = 1'b1;
        end
        chk("starve_first_refresh", found, 1'b1);
        l_req = 1'b1; l_we = 1'b1; l_addr = 16'h3344;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!l_ras_n && l_cas_n) found = 1'b1;
        end
        chk("starve_access_start", found, 1'b1);
        l_req = 1'b0;
        lates = 0; rcas = 0; acks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (l_late) lates++;
            if (l_ras_n && !l_cas_n) rcas++;
            if (l_ack) acks++;
        end
        chk("starve_late_pulses", lates, 1);
        chk("starve_refreshes", rcas, 1);
        chk("starve_acks", acks, 1);

        // asynchronous reset in the middle of CAS
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0F0F;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            a_req = 1'b0;
            if (!a_cas_n) found = 1'b1;
        end
        chk("rst_reached_cas", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_pins", {a_ras_n, a_cas_n, a_we_n, a_mux, a_ack}, 5'b11100);
        chk("rst_async_addr", a_da, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", {a_ready, a_ras_n, a_cas_n}, 3'b111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
